// File: rtl/alarm_timer_ctrl.sv
// Countdown timer and interval store for the anti-theft FSM.
// Four programmable second-delays, one-shot countdown with expired pulse, and a free-running 1 s tick.
module alarm_timer_ctrl #(
    parameter int TICK_DIV        = 27000000,
    parameter int VALUE_W         = 4,
    parameter int T_ARM_DEF       = 6,
    parameter int T_DRIVER_DEF    = 8,
    parameter int T_PASSENGER_DEF = 15,
    parameter int T_ALARM_DEF     = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               reprogram,
    input  logic [1:0]         param_sel,
    input  logic [VALUE_W-1:0] param_value,
    input  logic               start_timer,
    input  logic [1:0]         interval,
    input  logic               timer_reset,
    output logic               expired,
    output logic               busy,
    output logic [VALUE_W-1:0] remaining,
    output logic               tick
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [4*VALUE_W-1:0] PARAM_DEFS = {
        VALUE_W'(T_ALARM_DEF), VALUE_W'(T_PASSENGER_DEF),
        VALUE_W'(T_DRIVER_DEF), VALUE_W'(T_ARM_DEF)
    };

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic               start_prev_reg;
    logic [VALUE_W-1:0] param_reg [4];
    logic [3:0]         wr_en;
    logic [VALUE_W-1:0] remaining_reg, remaining_next;
    logic               expired_reg, expired_next;
    logic               busy_reg, tick_reg;
    logic               start_edge, wrap, load;
    logic [VALUE_W-1:0] sel_value;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wr_en
            assign wr_en[gi] = reprogram && (param_sel == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                param_reg[i] <= PARAM_DEFS[i*VALUE_W +: VALUE_W];
            end else if (wr_en[i]) begin
                param_reg[i] <= param_value;
            end
        end
    end

    assign start_edge = start_timer && !start_prev_reg;
    assign wrap       = (div_reg == DIV_LAST);
    assign sel_value  = param_reg[interval];

    // Loading a countdown realigns the divider so the first second is full length.
    always_comb begin
        if (load || wrap) begin
            div_next = '0;
        end else begin
            div_next = div_reg + DIV_W'(1);
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        expired_next   = 1'b0;
        load           = 1'b0;
        if (reprogram || timer_reset) begin
            state_next     = IDLE;
            remaining_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        load = 1'b1;
                        if (sel_value == '0) begin
                            state_next     = DONE;
                            remaining_next = '0;
                            expired_next   = 1'b1;
                        end else begin
                            state_next     = COUNT;
                            remaining_next = sel_value;
                        end
                    end
                end
                COUNT: begin
                    if (!start_timer) begin
                        state_next     = IDLE;
                        remaining_next = '0;
                    end else if (wrap) begin
                        remaining_next = remaining_reg - VALUE_W'(1);
                        if (remaining_reg == VALUE_W'(1)) begin
                            state_next   = DONE;
                            expired_next = 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Wait for the FSM to drop start so a held level cannot re-trigger.
                    if (!start_timer) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next     = IDLE;
                    remaining_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            div_reg        <= '0;
            start_prev_reg <= 1'b0;
            remaining_reg  <= '0;
            expired_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            tick_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            start_prev_reg <= start_timer;
            remaining_reg  <= remaining_next;
            expired_reg    <= expired_next;
            busy_reg       <= (state_next == COUNT);
            tick_reg       <= wrap && !load;
        end
    end

    assign expired   = expired_reg;
    assign busy      = busy_reg;
    assign remaining = remaining_reg;
    assign tick      = tick_reg;

endmodule

// File: doc/alarm_timer_ctrl.md
Name: alarm_timer_ctrl

Overview:
- Programmable countdown timer and parameter store for the car anti-theft FSM.
- Holds the four delay values (arm, driver, passenger, alarm-on) and accepts reprogramming of those values from the user switches.
- Starts a countdown of the selected interval when the FSM raises start_timer, and returns a one-cycle expired pulse.
- Also provides a free-running one-second tick for status-LED blinking.

Parameters:
- TICK_DIV, 27000000: clock cycles per one-second tick; must be ≥ 2.
- VALUE_W, 4: width of each stored interval, in seconds.
- T_ARM_DEF, 6: reset value of the arm-delay interval (index 0).
- T_DRIVER_DEF, 8: reset value of the driver-delay interval (index 1).
- T_PASSENGER_DEF, 15: reset value of the passenger-delay interval (index 2).
- T_ALARM_DEF, 10: reset value of the alarm-on interval (index 3).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- reprogram  input  1  write param_value into the register selected by param_sel; aborts any countdown.
- param_sel  input  2  register index for reprogram.
- param_value  input  VALUE_W  new interval, in seconds.
- start_timer  input  1  level from the FSM; a rising edge starts a countdown.
- interval  input  2  register index selecting the countdown length.
- timer_reset  input  1  synchronous abort of the countdown.
- expired  output  1  one-cycle pulse at end of countdown.
- busy  output  1  high while counting.
- remaining  output  VALUE_W  seconds left in the current countdown.
- tick  output  1  one-cycle pulse every TICK_DIV cycles.

Behaviour:
- Clock and reset: clock is clock; reset is reset, synchronous, active-high.
- Reset state:
  - Parameter registers load their *_DEF values.
  - State = IDLE; divider = 0; start_prev = 0.
  - expired = 0, busy = 0, remaining = 0, tick = 0.
- Tick divider:
  - Counts 0..TICK_DIV-1 and wraps; tick is registered and high for one cycle on each wrap.
  - The divider is cleared to 0 in the cycle a countdown loads, so the first second is a full TICK_DIV cycles.
- Start detection:
  - start_prev is a registered copy of start_timer.
  - A start edge is start_timer=1 with start_prev=0.
- Priority within a cycle: reset > reprogram > timer_reset > start edge > tick decrement.
- State machine:
  - IDLE:
    - On a start edge, latch regs[interval] into remaining, clear the divider, and go to COUNT.
    - If the latched value is 0, go directly to DONE with expired pulsed in the next cycle.
  - COUNT (busy=1):
    - On each tick, decrement remaining.
    - When a tick occurs with remaining==1: remaining becomes 0, expired=1 for exactly one cycle, go to DONE.
    - interval and register changes during COUNT do not affect the running count.
  - DONE (busy=0):
    - Stays until start_timer=0, then goes to IDLE.
    - Holding start_timer high never produces a second expired pulse.
- Timing contract: if the start edge is sampled in cycle k, expired is high in cycle k+1+N*TICK_DIV, where N is the latched value. This holds for N=0 too (expired at k+1).
- Aborts:
  - Conditions: start_timer deasserted in COUNT, timer_reset=1, or reprogram=1.
  - Effect: go to IDLE, remaining=0, busy=0, no expired pulse.
  - timer_reset in IDLE or DONE also forces IDLE.
  - A start edge coincident with timer_reset is ignored. The FSM must drop start_timer and reassert it to restart.
- Reprogram:
  - While reprogram=1, regs[param_sel] <= param_value every cycle (last value wins).
  - A value of 0 is legal and means immediate expiry.
- Restart after completion or abort: a fresh start edge reloads from the current register contents.
- Outputs are registered. remaining reflects the state after each clock edge.

Test Plan:
- Reset, TICK_DIV=4, interval=1, start_timer rises at cycle 10 and is held high → remaining=8 at cycle 11; expired high only at cycle 43; busy low from 43; no further pulse while start_timer stays high.
- reprogram with param_sel=2, param_value=3 for one cycle; then start with interval=2 → expired at start+1+12; with TICK_DIV=4 a start at cycle 20 gives expired at cycle 33.
- timer_reset pulsed 5 cycles after start (interval=0, value 6) → busy=0 and remaining=0 next cycle; no expired in the following 40 cycles; a new start edge counts a full 6 seconds.
- Program value 0 into index 3 and start with interval=3 → expired exactly 1 cycle after the start edge; busy never asserts.
- Change interval from 1 to 2 mid-count, and separately drop start_timer at second 2 → the first run still expires at the index-1 length; the second run aborts silently with remaining=0.
- reprogram and start edge in the same cycle → register is written, no countdown starts, busy=0; tick keeps pulsing every 4 cycles throughout.
